// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz generator/monitor pair.
// Contents:
//   XW_DEF/KW_DEF/SW_DEF : default widths of the term, the step counter and the seed
//   state_t              : monitor state encoding
//   ERR_*                : err_code values
//   collatz_next(x)      : one Collatz step, returns {ovf, next}; the generator
//                          datapath uses this to produce its next term
package collatz_pkg;

    localparam int XW_DEF = 16;
    localparam int KW_DEF = 20;
    localparam int SW_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_TRACK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SEED  = 2'b01;
    localparam logic [1:0] ERR_STEP  = 2'b10;
    localparam logic [1:0] ERR_PROTO = 2'b11;

    // 3x+1 needs two extra bits to be exact for any XW-bit x; anything that
    // lands in those bits cannot be represented as a term and is flagged.
    function automatic logic [XW_DEF:0] collatz_next(input logic [XW_DEF-1:0] x);
        logic [XW_DEF+1:0] wide;
        if (x[0])
            wide = ({2'b00, x} * (XW_DEF+2)'(3)) + (XW_DEF+2)'(1);
        else
            wide = {3'b000, x[XW_DEF-1:1]};
        return {|wide[XW_DEF+1:XW_DEF], wide[XW_DEF-1:0]};
    endfunction

endpackage

// File: rtl/collatz_monitor_if.sv
// Trajectory stream between the Collatz generator and its readers.
// Signals:
//   x     : current trajectory term
//   x_vld : one-cycle pulse, x holds a newly committed term
//   bs    : generator busy
// Modports: master (generator side, drives), slave (reader side, samples).
interface collatz_monitor_if #(
    parameter int XW = 16
);

    logic [XW-1:0] x;
    logic          x_vld;
    logic          bs;

    modport master (output x, output x_vld, output bs);
    modport slave  (input  x, input  x_vld, input  bs);

endinterface

// File: rtl/collatz_step_chk.sv
// Combinational check of one trajectory transition.
// Ports:
//   prev  : previously accepted term
//   x     : candidate next term
//   match : x is exactly the Collatz successor of prev
//   ovf   : the successor of prev does not fit in XW bits
module collatz_step_chk #(
    parameter int XW = 16
) (
    input  logic [XW-1:0] prev,
    input  logic [XW-1:0] x,
    output logic          match,
    output logic          ovf
);

    logic [XW+1:0] next_wide;

    // Successor is formed two bits wider than a term so that an odd prev
    // near the top of the range yields a visible overflow rather than a
    // silently wrapped value that might happen to equal x.
    always_comb begin
        next_wide = '0;
        if (prev[0])
            next_wide = ({2'b00, prev} * (XW+2)'(3)) + (XW+2)'(1);
        else
            next_wide = {3'b000, prev[XW-1:1]};
        ovf   = |next_wide[XW+1:XW];
        match = !ovf && (next_wide[XW-1:0] == x);
    end

endmodule

// File: rtl/collatz_monitor.sv
// Reader/checker for a Collatz trajectory stream.
// Latches the seed on st, checks every committed term against the Collatz
// rule, counts steps, tracks the peak term and reports done or the first
// error (with the step count at which it happened).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   co, st     : seed and start strobe
//   gen        : trajectory stream (x, x_vld, bs), slave side
//   steps      : terms accepted after the seed
//   peak       : largest term seen, seed included
//   done, err  : completion / latched error, held until the next st
//   err_code   : ERR_NONE, ERR_SEED, ERR_STEP or ERR_PROTO
//   err_step   : steps value when the error was latched
//   busy       : tracking in progress (ARMED or TRACK)
module collatz_monitor
    import collatz_pkg::*;
#(
    parameter int            XW        = XW_DEF,
    parameter int            KW        = KW_DEF,
    parameter int            SW        = SW_DEF,
    parameter logic [KW-1:0] MAX_STEPS = 20'hFFFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW-1:0]       co,
    input  logic                st,
    collatz_monitor_if.slave    gen,
    output logic [KW-1:0]       steps,
    output logic [XW-1:0]       peak,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [KW-1:0]       err_step,
    output logic                busy
);

    state_t        state;
    logic [SW-1:0] seed;
    logic [XW-1:0] prev;
    logic          bs_q;
    logic          bs_fell;
    logic          step_match;
    logic          step_ovf;

    collatz_step_chk #(.XW(XW)) u_step_chk (
        .prev  (prev),
        .x     (gen.x),
        .match (step_match),
        .ovf   (step_ovf)
    );

    assign bs_fell = bs_q && !gen.bs;
    assign busy    = (state == S_ARMED) || (state == S_TRACK);

    // Monitor FSM. A term arriving in the same cycle as the bs falling edge
    // is judged first; the protocol error is raised only if that term does
    // not finish the trajectory. Failing cycles leave steps/peak untouched,
    // so err_step always reports the count before the bad cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            seed     <= '0;
            prev     <= '0;
            bs_q     <= 1'b0;
            steps    <= '0;
            peak     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            err_step <= '0;
        end else begin
            bs_q <= gen.bs;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (st) begin
                        seed     <= co;
                        prev     <= '0;
                        steps    <= '0;
                        peak     <= '0;
                        done     <= 1'b0;
                        err_step <= '0;
                        if (co == '0) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_SEED;
                        end else begin
                            state    <= S_ARMED;
                            err      <= 1'b0;
                            err_code <= ERR_NONE;
                        end
                    end
                end
                S_ARMED: begin
                    if (gen.x_vld && (gen.x != XW'(seed))) begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_SEED;
                        err_step <= steps;
                    end else if (gen.x_vld && (seed == SW'(1))) begin
                        peak  <= gen.x;
                        prev  <= gen.x;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (bs_fell) begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_PROTO;
                        err_step <= steps;
                    end else if (gen.x_vld) begin
                        peak  <= gen.x;
                        prev  <= gen.x;
                        state <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (gen.x_vld && !step_ovf && step_match) begin
                        if ((steps == MAX_STEPS) || ((gen.x != XW'(1)) && bs_fell)) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_PROTO;
                            err_step <= steps;
                        end else begin
                            steps <= steps + 1'b1;
                            prev  <= gen.x;
                            if (gen.x > peak)
                                peak <= gen.x;
                            if (gen.x == XW'(1)) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end else if (gen.x_vld) begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        err_code <= step_ovf ? ERR_PROTO : ERR_STEP;
                        err_step <= steps;
                    end else if (bs_fell) begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_PROTO;
                        err_step <= steps;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/collatz_monitor.md
Name: collatz_monitor

Overview:
- Consumer/checker for the Collatz trajectory stream produced by the Collatz datapath/FSM pair.
- Captures the seed at start, then receives every trajectory term x and checks it against the Collatz rule (even: x/2; odd: 3x+1).
- Accumulates step count and peak value, and reports completion or the first error with its step index.
- Sits beside the generator in the top level; acts as the reader end of its x/bs interface and feeds a status/debug output.

Parameters:
- XW, 16, width of trajectory term x
- KW, 20, width of step counter
- SW, 8, width of seed co
- MAX_STEPS, 20'hFFFFF, step count at which tracking aborts with a protocol error

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- co  in  SW  seed, sampled with st
- st  in  1  start strobe from the same source that starts the generator
- x  in  XW  current trajectory term from the generator
- x_vld  in  1  one-cycle pulse: x holds a new committed term
- bs  in  1  generator busy
- steps  out  KW  terms accepted after the seed
- peak  out  XW  largest term seen, seed included
- done  out  1  trajectory reached 1 with no error; held until next st
- err  out  1  error latched; held until next st
- err_code  out  2  00 none, 01 bad seed, 10 bad transition, 11 protocol
- err_step  out  KW  value of steps when the error was latched
- busy  out  1  high in ARMED or TRACK

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; steps, peak, err_step = 0; done, err, busy = 0; err_code = 00. Reset mid-trajectory abandons tracking immediately.
- States: IDLE, ARMED, TRACK, DONE, ERR.
- Start rule: st=1 in IDLE/DONE/ERR clears all outputs and latches seed = co.
  - co = 0: go to ERR with code 01, err_step = 0.
  - co ≠ 0: go to ARMED.
  - st is ignored in ARMED/TRACK.
- ARMED: first x_vld must carry x == {0,seed}.
  - Match: peak = x, prev = x, go to TRACK. If seed == 1, go directly to DONE with steps = 0.
  - Mismatch: ERR, code 01.
- TRACK, on each x_vld:
  - Expected value: prev even → prev>>1; prev odd → 3*prev+1, computed at XW+2 bits.
  - Expected value ≥ 2^XW: ERR, code 11 (overflow).
  - x ≠ expected: ERR, code 10.
  - Otherwise: steps += 1, prev = x, peak = max(peak, x).
  - If x == 1 after the update: DONE.
- Protocol errors (code 11), all from TRACK or ARMED:
  - bs falls before DONE.
  - steps would exceed MAX_STEPS.
- x_vld in IDLE/DONE/ERR is ignored.
- Latency: all outputs registered. done/err assert in the cycle after the x_vld or bs edge that causes them.
- err_step captures steps before any increment in the failing cycle.
- Simultaneous x_vld and bs falling edge in the same cycle: check x_vld first. If that term is 1, result is DONE (no protocol error).
- busy = (state==ARMED || state==TRACK).
- done and err are never both 1.

Decomposition:
- Shared package collatz_pkg holds:
  - XW/KW/SW defaults
  - state enum type
  - err_code constants ERR_NONE, ERR_SEED, ERR_STEP, ERR_PROTO
  - function collatz_next(x) returning {ovf, next}
- The generator datapath can reuse collatz_next.
- One natural sub-module: collatz_step_chk, combinational (prev, x) → {match, ovf}. Everything else is one FSM module.

Test Plan:
- co=6, st, stream 6,3,10,5,16,8,4,2,1 with x_vld pulses → done=1, steps=8, peak=16, err=0.
- co=27, full 112-term trajectory → done=1, steps=111, peak=9232.
- co=7, stream 7,22,11,35 → err=1, code=10, err_step=2, peak=22.
- co=0, st → err=1, code=01, err_step=0 in the next cycle; x_vld pulses are ignored afterwards.
- co=5, stream 5,16, then bs drops → err=1, code=11, err_step=1.
- Reset mid-trajectory (co=9, after 4 terms pull rst_n low one cycle), then co=1, st, x=1 → all outputs cleared by reset, then done=1, steps=0, peak=1.
